// File: rtl/ex_mem_latch_pkg.sv
// Shared definitions for the EX/MEM pipeline register: set-condition encodings
// and default datapath widths.
package ex_mem_latch_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_REG_BITS = 3;
   localparam int DEF_CNT_W    = 16;

   typedef enum logic [1:0] {
      SET_SEQ = 2'd0,
      SET_SLT = 2'd1,
      SET_SLE = 2'd2,
      SET_SCO = 2'd3
   } set_typ_t;

endpackage

// File: rtl/ex_mem_latch_set_checker.sv
// Set-condition evaluator: picks one ALU flag by set type and widens it into
// a WIDTH-bit 0/1 result.
module set_checker
   import ex_mem_latch_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [1:0]       set_typ,
   input  logic             zero,
   input  logic             neg,
   input  logic             ofl,
   output logic [WIDTH-1:0] set_val
);

   logic flag;

   always_comb begin
      flag = 1'b0;
      case (set_typ_t'(set_typ))
         SET_SEQ: flag = zero;
         SET_SLT: flag = neg;
         SET_SLE: flag = neg | zero;
         SET_SCO: flag = ofl;
         default: flag = 1'b0;
      endcase
   end

   assign set_val = {{(WIDTH-1){1'b0}}, flag};

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: merges set results with the ALU result, registers
// result/control/store data, and exposes forwarding, load-use and stall status.
module ex_mem_latch
   import ex_mem_latch_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int REG_BITS = DEF_REG_BITS,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                ex_valid,
   input  logic [WIDTH-1:0]    ex_alu_out,
   input  logic                ex_zero,
   input  logic                ex_neg,
   input  logic                ex_ofl,
   input  logic [1:0]          ex_set_typ,
   input  logic                ex_is_set,
   input  logic                ex_wr_en,
   input  logic [REG_BITS-1:0] ex_wr_reg,
   input  logic                ex_mem_rd,
   input  logic                ex_mem_wr,
   input  logic [WIDTH-1:0]    ex_mem_wdata,
   input  logic                ex_halt,
   input  logic                ex_err,
   output logic                mem_valid,
   output logic [WIDTH-1:0]    mem_result,
   output logic                mem_wr_en,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                mem_halt,
   output logic                mem_err,
   output logic [REG_BITS-1:0] mem_wr_reg,
   output logic [WIDTH-1:0]    mem_wdata,
   output logic                fwd_valid,
   output logic [REG_BITS-1:0] fwd_reg,
   output logic [WIDTH-1:0]    fwd_data,
   output logic                load_use,
   output logic                halt_seen,
   output logic [CNT_W-1:0]    stall_cnt
);

   logic [WIDTH-1:0] set_val;
   logic [WIDTH-1:0] next_result;
   logic             load_v;

   set_checker #(.WIDTH(WIDTH)) u_set_checker (
      .set_typ (ex_set_typ),
      .zero    (ex_zero),
      .neg     (ex_neg),
      .ofl     (ex_ofl),
      .set_val (set_val)
   );

   assign next_result = ex_is_set ? set_val : ex_alu_out;
   assign load_v      = ex_valid & ~halt_seen;

   // Flush only bubbles the control bits; data fields keep their last values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid  <= 1'b0;
         mem_wr_en  <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_halt   <= 1'b0;
         mem_err    <= 1'b0;
         mem_result <= '0;
         mem_wr_reg <= '0;
         mem_wdata  <= '0;
      end else if (flush) begin
         mem_valid  <= 1'b0;
         mem_wr_en  <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_halt   <= 1'b0;
         mem_err    <= 1'b0;
      end else if (!stall) begin
         mem_valid  <= load_v;
         mem_wr_en  <= ex_wr_en  & load_v;
         mem_rd     <= ex_mem_rd & load_v;
         mem_wr     <= ex_mem_wr & load_v;
         mem_halt   <= ex_halt   & load_v;
         mem_err    <= ex_err    & load_v;
         mem_result <= next_result;
         mem_wr_reg <= ex_wr_reg;
         mem_wdata  <= ex_mem_wdata;
      end
   end

   // A halt counts as seen once it leaves this stage; flush only kills the incoming slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt_seen <= 1'b0;
      end else if (mem_valid && mem_halt && !stall) begin
         halt_seen <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stall && !flush && mem_valid && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign fwd_valid = mem_valid & mem_wr_en & ~mem_rd;
   assign fwd_reg   = mem_wr_reg;
   assign fwd_data  = mem_result;
   assign load_use  = mem_valid & mem_wr_en & mem_rd;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Scoreboard bench for ex_mem_latch: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_ex_mem_latch;

   typedef struct packed {
      logic        stall, flush, valid;
      logic [15:0] alu;
      logic        zero, neg, ofl;
      logic [1:0]  set_typ;
      logic        is_set, wr_en;
      logic [2:0]  wr_reg;
      logic        rd, wr;
      logic [15:0] wdata;
      logic        halt, err;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [15:0] result;
      logic [2:0]  wr_reg;
      logic        wr_en, rd, wr, halt, err;
      logic [15:0] wdata;
      logic        fwd_valid, load_use, halt_seen;
      logic [15:0] stall_cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
   logic [15:0] ex_alu_out = '0;
   logic        ex_zero = 1'b0, ex_neg = 1'b0, ex_ofl = 1'b0;
   logic [1:0]  ex_set_typ = '0;
   logic        ex_is_set = 1'b0, ex_wr_en = 1'b0;
   logic [2:0]  ex_wr_reg = '0;
   logic        ex_mem_rd = 1'b0, ex_mem_wr = 1'b0;
   logic [15:0] ex_mem_wdata = '0;
   logic        ex_halt = 1'b0, ex_err = 1'b0;

   logic        mem_valid, mem_wr_en, mem_rd, mem_wr, mem_halt, mem_err;
   logic [15:0] mem_result, mem_wdata, fwd_data, stall_cnt;
   logic [2:0]  mem_wr_reg, fwd_reg;
   logic        fwd_valid, load_use, halt_seen;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   ex_mem_latch dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_out(ex_alu_out), .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_ofl(ex_ofl),
      .ex_set_typ(ex_set_typ), .ex_is_set(ex_is_set), .ex_wr_en(ex_wr_en),
      .ex_wr_reg(ex_wr_reg), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_mem_wdata(ex_mem_wdata), .ex_halt(ex_halt), .ex_err(ex_err),
      .mem_valid(mem_valid), .mem_result(mem_result), .mem_wr_en(mem_wr_en),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_halt(mem_halt), .mem_err(mem_err),
      .mem_wr_reg(mem_wr_reg), .mem_wdata(mem_wdata), .fwd_valid(fwd_valid),
      .fwd_reg(fwd_reg), .fwd_data(fwd_data), .load_use(load_use),
      .halt_seen(halt_seen), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic stim_t mk_stim(logic st, logic fl, logic v, logic [15:0] alu,
                                     logic z, logic n, logic o, logic [1:0] typ,
                                     logic is_set, logic wr_en, logic [2:0] reg_id,
                                     logic rd, logic wr, logic [15:0] wdata,
                                     logic halt, logic err);
      stim_t s;
      s = '{st, fl, v, alu, z, n, o, typ, is_set, wr_en, reg_id, rd, wr, wdata, halt, err};
      return s;
   endfunction

   function automatic exp_t mk_exp(logic v, logic [15:0] res, logic [2:0] reg_id,
                                   logic wr_en, logic rd, logic wr, logic halt,
                                   logic err, logic [15:0] wdata, logic fv, logic lu,
                                   logic hs, logic [15:0] cnt);
      exp_t e;
      e = '{v, res, reg_id, wr_en, rd, wr, halt, err, wdata, fv, lu, hs, cnt};
      return e;
   endfunction

   task automatic cmp(string name, logic [63:0] got, logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", name, got, want, $time);
      end
   endtask

   task automatic checkOutput(exp_t e);
      cmp("ctrl", 64'({mem_valid, mem_wr_en, mem_rd, mem_wr, mem_halt, mem_err}),
          64'({e.valid, e.wr_en, e.rd, e.wr, e.halt, e.err}));
      cmp("result", 64'(mem_result), 64'(e.result));
      cmp("wr_reg", 64'(mem_wr_reg), 64'(e.wr_reg));
      cmp("wdata", 64'(mem_wdata), 64'(e.wdata));
      cmp("fwd_flags", 64'({fwd_valid, load_use}), 64'({e.fwd_valid, e.load_use}));
      cmp("fwd_path", 64'({fwd_reg, fwd_data}), 64'({e.wr_reg, e.result}));
      cmp("halt_seen", 64'(halt_seen), 64'(e.halt_seen));
      cmp("stall_cnt", 64'(stall_cnt), 64'(e.stall_cnt));
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   // Called just after a negedge: drive, queue the post-posedge expectation, move on.
   task automatic applyStimulus(stim_t s, exp_t e, bit do_check);
      stall = s.stall; flush = s.flush; ex_valid = s.valid; ex_alu_out = s.alu;
      ex_zero = s.zero; ex_neg = s.neg; ex_ofl = s.ofl; ex_set_typ = s.set_typ;
      ex_is_set = s.is_set; ex_wr_en = s.wr_en; ex_wr_reg = s.wr_reg;
      ex_mem_rd = s.rd; ex_mem_wr = s.wr; ex_mem_wdata = s.wdata;
      ex_halt = s.halt; ex_err = s.err;
      if (do_check) exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   initial begin
      stim_t sat_s;
      exp_t  zero_e;
      zero_e = '0;

      $display("[TB] reset state");
      exp_q.push_back(zero_e);
      @(negedge clk); #1;
      rst = 1'b1;

      $display("[TB] set instructions and ALU pass-through");
      applyStimulus(mk_stim(0,0,1,16'h7777,0,1,0,2'd1,1,1,3'd5,0,0,16'hAAAA,0,0),
                    mk_exp(1,16'h0001,3'd5,1,0,0,0,0,16'hAAAA,1,0,0,16'd0), 1);
      applyStimulus(mk_stim(0,0,1,16'h7777,0,1,0,2'd0,1,1,3'd2,0,0,16'h0000,0,0),
                    mk_exp(1,16'h0000,3'd2,1,0,0,0,0,16'h0000,1,0,0,16'd0), 1);
      applyStimulus(mk_stim(0,0,1,16'h7777,1,0,0,2'd2,1,1,3'd3,0,0,16'h0000,0,0),
                    mk_exp(1,16'h0001,3'd3,1,0,0,0,0,16'h0000,1,0,0,16'd0), 1);
      applyStimulus(mk_stim(0,0,1,16'h7777,0,0,1,2'd3,1,1,3'd4,0,0,16'h0000,0,0),
                    mk_exp(1,16'h0001,3'd4,1,0,0,0,0,16'h0000,1,0,0,16'd0), 1);
      applyStimulus(mk_stim(0,0,1,16'h1234,0,0,1,2'd3,0,1,3'd1,0,0,16'h0000,0,0),
                    mk_exp(1,16'h1234,3'd1,1,0,0,0,0,16'h0000,1,0,0,16'd0), 1);

      $display("[TB] three-cycle stall");
      for (int k = 1; k <= 3; k++)
         applyStimulus(mk_stim(1,0,1,16'hFFFF,0,0,0,2'd0,0,1,3'd7,0,0,16'h3333,0,0),
                       mk_exp(1,16'h1234,3'd1,1,0,0,0,0,16'h0000,1,0,0,16'(k)), 1);

      $display("[TB] store, then stall+flush, then stall on a bubble");
      applyStimulus(mk_stim(0,0,1,16'h0040,0,0,0,2'd0,0,0,3'd6,0,1,16'hBEEF,0,0),
                    mk_exp(1,16'h0040,3'd6,0,0,1,0,0,16'hBEEF,0,0,0,16'd3), 1);
      applyStimulus(mk_stim(1,1,1,16'h9999,0,0,0,2'd0,0,1,3'd0,0,0,16'h1111,0,0),
                    mk_exp(0,16'h0040,3'd6,0,0,0,0,0,16'hBEEF,0,0,0,16'd3), 1);
      applyStimulus(mk_stim(1,0,1,16'h9999,0,0,0,2'd0,0,1,3'd0,0,0,16'h1111,0,0),
                    mk_exp(0,16'h0040,3'd6,0,0,0,0,0,16'hBEEF,0,0,0,16'd3), 1);

      $display("[TB] load-use, invalid slot, error");
      applyStimulus(mk_stim(0,0,1,16'h0080,0,0,0,2'd0,0,1,3'd2,1,0,16'h0000,0,0),
                    mk_exp(1,16'h0080,3'd2,1,1,0,0,0,16'h0000,0,1,0,16'd3), 1);
      applyStimulus(mk_stim(0,0,0,16'h5555,0,0,0,2'd0,0,1,3'd7,1,1,16'h2222,1,1),
                    mk_exp(0,16'h5555,3'd7,0,0,0,0,0,16'h2222,0,0,0,16'd3), 1);
      applyStimulus(mk_stim(0,0,1,16'h0000,0,0,0,2'd0,0,0,3'd0,0,0,16'h0000,0,1),
                    mk_exp(1,16'h0000,3'd0,0,0,0,0,1,16'h0000,0,0,0,16'd3), 1);

      $display("[TB] halt handling");
      applyStimulus(mk_stim(0,0,1,16'h0000,0,0,0,2'd0,0,0,3'd0,0,0,16'h0000,1,0),
                    mk_exp(1,16'h0000,3'd0,0,0,0,1,0,16'h0000,0,0,0,16'd3), 1);
      applyStimulus(mk_stim(1,0,1,16'h6666,0,0,0,2'd0,0,1,3'd5,0,0,16'h0000,0,0),
                    mk_exp(1,16'h0000,3'd0,0,0,0,1,0,16'h0000,0,0,0,16'd4), 1);
      applyStimulus(mk_stim(0,1,1,16'h7777,0,0,0,2'd0,0,1,3'd5,0,0,16'h0000,0,0),
                    mk_exp(0,16'h0000,3'd0,0,0,0,0,0,16'h0000,0,0,1,16'd4), 1);
      applyStimulus(mk_stim(0,0,1,16'h4321,0,0,0,2'd0,0,1,3'd3,0,0,16'h0000,0,0),
                    mk_exp(0,16'h4321,3'd3,0,0,0,0,0,16'h0000,0,0,1,16'd4), 1);

      $display("[TB] reset, then saturating stall counter");
      rst = 1'b0;
      #1;
      checkOutput(zero_e);
      @(negedge clk); #1;
      rst = 1'b1;
      applyStimulus(mk_stim(0,0,1,16'hABCD,0,0,0,2'd0,0,1,3'd1,0,0,16'h0000,0,0),
                    mk_exp(1,16'hABCD,3'd1,1,0,0,0,0,16'h0000,1,0,0,16'd0), 1);
      sat_s = mk_stim(1,0,1,16'hABCD,0,0,0,2'd0,0,1,3'd1,0,0,16'h0000,0,0);
      for (int k = 1; k <= 65541; k++) begin
         applyStimulus(sat_s,
                       mk_exp(1,16'hABCD,3'd1,1,0,0,0,0,16'h0000,1,0,0,
                              (k > 65535) ? 16'hFFFF : 16'(k)),
                       (k <= 2) || (k >= 65534));
      end

      $display("[TB] asynchronous reset mid-stall");
      #2;
      rst = 1'b0;
      #1;
      checkOutput(zero_e);
      @(negedge clk); #1;
      rst = 1'b1;
      applyStimulus(mk_stim(0,0,1,16'h0005,0,0,0,2'd0,0,1,3'd2,0,0,16'h0000,0,0),
                    mk_exp(1,16'h0005,3'd2,1,0,0,0,0,16'h0000,1,0,0,16'd0), 1);

      cmp("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
